// File: rtl/stq_buff_if.sv
// Handshake bundle for stq_buff_array: per-unit write channels and the
// registered valid/ready output port. master drives writes, slave is the array.
interface stq_buff_if #(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 4,
    parameter int ROW_IDX_W = 16,
    parameter int VAL_W     = 32
);
    logic [NUM_UNITS-1:0]           in_valid;
    logic [NUM_UNITS*ROW_IDX_W-1:0] in_row_idx;
    logic [NUM_UNITS*VAL_W-1:0]     in_value;
    logic [NUM_UNITS-1:0]           in_ready;
    logic                           out_valid;
    logic                           out_ready;
    logic [TAG_W-1:0]               out_tag;
    logic [VAL_W-1:0]               out_value;
    logic [NUM_UNITS-1:0]           out_unit;

    modport master (
        output in_valid, in_row_idx, in_value, out_ready,
        input  in_ready, out_valid, out_tag, out_value, out_unit
    );

    modport slave (
        input  in_valid, in_row_idx, in_value, out_ready,
        output in_ready, out_valid, out_tag, out_value, out_unit
    );
endinterface

// File: rtl/stq_buff_array.sv
// N-unit tagged store-queue buffer draining in global tag order.
// Ports: clk, rst_b (async low), global_en, restart, unit_done, bus
// (stq_buff_if.slave), svc_idx, all_done, order_err. Macro: STQ_SUM_EN.
module stq_buff_array #(
    parameter int NUM_UNITS = 4,
    parameter int ASIZE     = 4,
    parameter int TAG_W     = 4,
    parameter int ROW_IDX_W = 16,
    parameter int VAL_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 global_en,
    input  logic                 restart,
    input  logic [NUM_UNITS-1:0] unit_done,
    stq_buff_if.slave            bus,
    output logic [TAG_W-1:0]     svc_idx,
    output logic                 all_done,
    output logic                 order_err
);
    localparam int DEPTH = 1 << ASIZE;

    typedef enum logic {SERVE, DONE} state_t;

    state_t state;

    logic [TAG_W+VAL_W-1:0] mem [NUM_UNITS][DEPTH];
    logic [ASIZE:0]         wptr [NUM_UNITS];
    logic [ASIZE:0]         rptr [NUM_UNITS];
    logic [TAG_W-1:0]       last_tag [NUM_UNITS];
    logic [NUM_UNITS-1:0]   seen;
    logic [NUM_UNITS-1:0]   done_lat;

    logic                   out_valid_q;
    logic [TAG_W-1:0]       out_tag_q;
    logic [VAL_W-1:0]       out_value_q;
    logic [NUM_UNITS-1:0]   out_unit_q;

    logic [TAG_W-1:0]       head_tag [NUM_UNITS];
    logic [VAL_W-1:0]       head_val [NUM_UNITS];
    logic [TAG_W-1:0]       in_tag [NUM_UNITS];
    logic [VAL_W-1:0]       in_val [NUM_UNITS];
    logic [NUM_UNITS-1:0]   head_valid;
    logic [NUM_UNITS-1:0]   full;
    logic [NUM_UNITS-1:0]   wr;
    logic [NUM_UNITS-1:0]   match;
    logic [NUM_UNITS-1:0]   clr;
    logic [NUM_UNITS-1:0]   sel;
    logic [NUM_UNITS-1:0]   pop;
    logic [VAL_W-1:0]       sel_val;

    logic load;
    logic accept;
    logic go_done;
    logic serve;
    logic do_pop;
    logic do_inc;

    assign bus.in_ready  = ~full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_value = out_value_q;
    assign bus.out_unit  = out_unit_q;

    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            head_valid[u] = wptr[u] != rptr[u];
            full[u] = (wptr[u][ASIZE] != rptr[u][ASIZE]) &&
                      (wptr[u][ASIZE-1:0] == rptr[u][ASIZE-1:0]);
            {head_tag[u], head_val[u]} = mem[u][rptr[u][ASIZE-1:0]];
            // Tag is the top TAG_W bits of the row index.
            in_tag[u] = TAG_W'(bus.in_row_idx[u*ROW_IDX_W +: ROW_IDX_W]
                               >> (ROW_IDX_W - TAG_W));
            in_val[u] = bus.in_value[u*VAL_W +: VAL_W];
            wr[u] = global_en && bus.in_valid[u] && !full[u] &&
                    !done_lat[u];
            match[u] = head_valid[u] && (head_tag[u] == svc_idx);
            // A unit is clear when it can hold nothing more for svc_idx.
            clr[u] = head_valid[u] ? (head_tag[u] != svc_idx) :
                     (done_lat[u] || (seen[u] && last_tag[u] != svc_idx));
        end
    end

`ifdef STQ_SUM_EN
    always_comb begin
        sel     = match;
        sel_val = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (match[u]) sel_val = sel_val + head_val[u];
        end
    end
`else
    // Descending scan leaves the lowest matching unit selected.
    always_comb begin
        sel     = '0;
        sel_val = '0;
        for (int u = NUM_UNITS - 1; u >= 0; u--) begin
            if (match[u]) begin
                sel     = '0;
                sel[u]  = 1'b1;
                sel_val = head_val[u];
            end
        end
    end
`endif

    assign load    = !out_valid_q || bus.out_ready;
    assign accept  = out_valid_q && bus.out_ready;
    assign go_done = (&done_lat) && !(|head_valid) &&
                     (!out_valid_q || bus.out_ready);
    assign serve   = (state == SERVE) && !restart;
    assign do_pop  = serve && !go_done && load && (|match);
    assign do_inc  = serve && !go_done && (&clr) && !(|match);
    assign pop     = do_pop ? sel : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                wptr[u] <= '0;
                rptr[u] <= '0;
            end
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (wr[u])  wptr[u] <= wptr[u] + (ASIZE+1)'(1);
                if (pop[u]) rptr[u] <= rptr[u] + (ASIZE+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (wr[u]) mem[u][wptr[u][ASIZE-1:0]] <= {in_tag[u], in_val[u]};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= SERVE;
            svc_idx     <= '0;
            all_done    <= 1'b0;
            order_err   <= 1'b0;
            seen        <= '0;
            done_lat    <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_value_q <= '0;
            out_unit_q  <= '0;
            for (int u = 0; u < NUM_UNITS; u++) last_tag[u] <= '0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (wr[u]) begin
                    last_tag[u] <= in_tag[u];
                    seen[u]     <= 1'b1;
                    if (seen[u] && in_tag[u] < last_tag[u])
                        order_err <= 1'b1;
                end
            end
            done_lat <= done_lat | unit_done;
            if (accept) out_valid_q <= 1'b0;
            if (do_pop) begin
                out_valid_q <= 1'b1;
                out_tag_q   <= svc_idx;
                out_value_q <= sel_val;
                out_unit_q  <= sel;
            end
            if (restart) begin
                state    <= SERVE;
                svc_idx  <= '0;
                all_done <= 1'b0;
                seen     <= '0;
                done_lat <= '0;
                for (int u = 0; u < NUM_UNITS; u++) last_tag[u] <= '0;
            end else begin
                unique case (state)
                    SERVE: begin
                        if (go_done) begin
                            state    <= DONE;
                            all_done <= 1'b1;
                        end else if (do_inc) begin
                            svc_idx <= svc_idx + TAG_W'(1);
                        end
                    end
                    DONE: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stq_buff_array.sv
// Randomized and directed bench for stq_buff_array against a
// tag-sorted reference model of the expected drain order.
module tb_stq_buff_array;
    localparam int NU = 4;
    localparam int AS = 4;
    localparam int TW = 4;
    localparam int RW = 16;
    localparam int VW = 32;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          global_en = 1'b0;
    logic          restart = 1'b0;
    logic [NU-1:0] unit_done = '0;
    logic [TW-1:0] svc_idx;
    logic          all_done;
    logic          order_err;

    int n_chk = 0;
    int n_err = 0;

    logic [39:0] got_q [$];

    stq_buff_if #(
        .NUM_UNITS(NU), .TAG_W(TW), .ROW_IDX_W(RW), .VAL_W(VW)
    ) bus ();

    stq_buff_array #(
        .NUM_UNITS(NU), .ASIZE(AS), .TAG_W(TW),
        .ROW_IDX_W(RW), .VAL_W(VW)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .global_en(global_en),
        .restart(restart),
        .unit_done(unit_done),
        .bus(bus),
        .svc_idx(svc_idx),
        .all_done(all_done),
        .order_err(order_err)
    );

    always #5 clk = ~clk;

    // Accepts happen at the next rising edge; inputs only move at edge+1.
    always @(negedge clk) begin
        if (rst_b && bus.out_valid && bus.out_ready)
            got_q.push_back({bus.out_tag, bus.out_unit, bus.out_value});
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        global_en      = 1'b0;
        bus.in_valid   = '0;
        bus.in_row_idx = '0;
        bus.in_value   = '0;
        unit_done      = '0;
        restart        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        bus.out_ready = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        got_q.delete();
    endtask

    task automatic set_in(input int u, input logic [3:0] tg,
                          input logic [31:0] v);
        logic [11:0] lo;
        lo = 12'($urandom);
        bus.in_valid[u] = 1'b1;
        bus.in_row_idx[u*RW +: RW] = {tg, lo};
        bus.in_value[u*VW +: VW] = v;
    endtask

    task automatic wr1(input int u, input logic [3:0] tg,
                       input logic [31:0] v);
        global_en = 1'b1;
        set_in(u, tg, v);
        tick();
        global_en = 1'b0;
        bus.in_valid = '0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (all_done) break;
            tick();
        end
    endtask

    task automatic rand_pass(input int p);
        logic [3:0]  tg [NU][16];
        logic [31:0] vl [NU][16];
        int          n [NU];
        logic [39:0] exp_q [$];
        int          t;
        int          m;
        got_q.delete();
        for (int u = 0; u < NU; u++) begin
            n[u] = $urandom_range(1, 10);
            t = $urandom_range(0, 3);
            for (int k = 0; k < n[u]; k++) begin
                tg[u][k] = 4'(t);
                vl[u][k] = $urandom;
                t = t + $urandom_range(0, 2);
                if (t > 15) t = 15;
            end
        end
        // Drain order: ascending tag; within a tag, by unit then age.
        for (int tt = 0; tt < 16; tt++) begin
`ifdef STQ_SUM_EN
            m = 0;
            for (int u = 0; u < NU; u++) begin
                int c;
                c = 0;
                for (int k = 0; k < n[u]; k++) if (tg[u][k] == 4'(tt)) c++;
                if (c > m) m = c;
            end
            for (int r = 0; r < m; r++) begin
                logic [3:0]  msk;
                logic [31:0] sum;
                msk = '0;
                sum = '0;
                for (int u = 0; u < NU; u++) begin
                    int c;
                    c = 0;
                    for (int k = 0; k < n[u]; k++) begin
                        if (tg[u][k] == 4'(tt)) begin
                            if (c == r) begin
                                msk[u] = 1'b1;
                                sum = sum + vl[u][k];
                            end
                            c++;
                        end
                    end
                end
                exp_q.push_back({4'(tt), msk, sum});
            end
`else
            m = 0;
            for (int u = 0; u < NU; u++)
                for (int k = 0; k < n[u]; k++)
                    if (tg[u][k] == 4'(tt))
                        exp_q.push_back({4'(tt), 4'(1 << u), vl[u][k]});
`endif
        end
        bus.out_ready = 1'b0;
        global_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = '0;
            for (int u = 0; u < NU; u++)
                if (c < n[u]) set_in(u, tg[u][c], vl[u][c]);
            tick();
        end
        idle();
        unit_done = '1;
        tick();
        unit_done = '0;
        for (int i = 0; i < 600; i++) begin
            if (all_done) break;
            bus.out_ready = ($urandom % 4) != 0;
            tick();
        end
        bus.out_ready = 1'b0;
        chk($sformatf("rnd%0d_cnt", p), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("rnd%0d_ent%0d", p, i), got_q[i], exp_q[i]);
        chk($sformatf("rnd%0d_done", p), all_done, 1);
        chk($sformatf("rnd%0d_oerr", p), order_err, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk($sformatf("rnd%0d_rst_done", p), all_done, 0);
    endtask

    initial begin
        logic [39:0] e2 [4];

        // Reset state and idle.
        do_reset();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 4'hF);
        chk("rst_svc", svc_idx, 0);
        chk("rst_all_done", all_done, 0);
        chk("rst_order_err", order_err, 0);
        chk("rst_out_bus", {bus.out_tag, bus.out_value, bus.out_unit}, 0);
        repeat (3) tick();
        chk("idle_svc", svc_idx, 0);
        chk("idle_out_valid", bus.out_valid, 0);

        // Two units, in-order drain.
        do_reset();
        bus.out_ready = 1'b1;
        wr1(0, 4'd0, 32'h10);
        wr1(0, 4'd0, 32'h11);
        wr1(0, 4'd1, 32'h12);
        wr1(1, 4'd2, 32'h20);
        unit_done = 4'hF;
        tick();
        unit_done = '0;
        wait_done(100);
        e2[0] = {4'd0, 4'b0001, 32'h10};
        e2[1] = {4'd0, 4'b0001, 32'h11};
        e2[2] = {4'd1, 4'b0001, 32'h12};
        e2[3] = {4'd2, 4'b0010, 32'h20};
        chk("t2_cnt", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            chk($sformatf("t2_ent%0d", i), got_q[i], e2[i]);
        chk("t2_all_done", all_done, 1);

        // Full FIFO with the output stalled.
        do_reset();
        wr1(0, 4'd0, 32'hAA);
        tick();
        chk("t3_stall_valid", bus.out_valid, 1);
        for (int k = 0; k < 16; k++) wr1(2, 4'd0, 32'(k));
        chk("t3_full", bus.in_ready[2], 0);
        wr1(2, 4'd0, 32'd99);
        bus.out_ready = 1'b1;
        unit_done = 4'hF;
        tick();
        unit_done = '0;
        wait_done(100);
        chk("t3_cnt", got_q.size(), 17);
        if (got_q.size() > 0)
            chk("t3_first", got_q[0], {4'd0, 4'b0001, 32'hAA});
        for (int k = 1; k < 17 && k < got_q.size(); k++)
            chk($sformatf("t3_ent%0d", k), got_q[k][35:0],
                {4'b0100, 32'(k - 1)});
        chk("t3_done", all_done, 1);

        // Same tag on two units.
        do_reset();
        bus.out_ready = 1'b1;
        global_en = 1'b1;
        set_in(0, 4'd5, 32'd7);
        set_in(3, 4'd5, 32'd9);
        unit_done = 4'b0110;
        tick();
        idle();
        unit_done = 4'b1001;
        tick();
        unit_done = '0;
        wait_done(60);
`ifdef STQ_SUM_EN
        chk("t4_cnt", got_q.size(), 1);
        if (got_q.size() > 0)
            chk("t4_sum", got_q[0], {4'd5, 4'b1001, 32'd16});
`else
        chk("t4_cnt", got_q.size(), 2);
        if (got_q.size() > 1) begin
            chk("t4_u0", got_q[0], {4'd5, 4'b0001, 32'd7});
            chk("t4_u3", got_q[1], {4'd5, 4'b1000, 32'd9});
        end
`endif
        chk("t4_done", all_done, 1);

        // Order error is sticky across restart.
        do_reset();
        wr1(1, 4'd3, 32'h31);
        wr1(1, 4'd1, 32'h11);
        chk("t5_oerr_set", order_err, 1);
        bus.out_ready = 1'b1;
        unit_done = 4'hF;
        tick();
        unit_done = '0;
        wait_done(80);
        chk("t5_done", all_done, 1);
        chk("t5_cnt", got_q.size(), 2);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t5_oerr_restart", order_err, 1);
        chk("t5_svc_restart", svc_idx, 0);
        chk("t5_done_restart", all_done, 0);
        do_reset();
        chk("t5_oerr_reset", order_err, 0);

        // svc_idx wrap and async reset with output pending.
        do_reset();
        bus.out_ready = 1'b1;
        unit_done = 4'b1110;
        wr1(0, 4'd15, 32'h15);
        unit_done = '0;
        wr1(0, 4'd0, 32'h05);
        for (int i = 0; i < 40; i++) begin
            if (svc_idx == 4'd15) break;
            tick();
        end
        chk("t6_reach15", svc_idx, 15);
        for (int i = 0; i < 5; i++) begin
            if (svc_idx != 4'd15) break;
            tick();
        end
        chk("t6_wrap", svc_idx, 0);
        bus.out_ready = 1'b0;
        tick();
        chk("t6_pend", {bus.out_valid, bus.out_tag, bus.out_value},
            {1'b1, 4'd0, 32'h05});
        rst_b = 1'b0;
        #1;
        chk("t6_async_valid", bus.out_valid, 0);
        chk("t6_async_ready", bus.in_ready, 4'hF);
        chk("t6_async_svc", svc_idx, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        // Randomized passes with restart between them.
        do_reset();
        for (int p = 0; p < 6; p++) rand_pass(p);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
